hsv_color_track: RTL and testbench
==================================

Name: hsv_color_track

Overview:
- Consumes the HSV pixel stream (h 0..360, s 0..256, v 0..255, plus vs/hs/de) from the RGB-to-HSV stage.
- Thresholds each pixel against a programmable HSV window to produce a 1-bit mask stream, with syncs delayed to match.
- Accumulates per-frame bounding box and hit count of masked pixels.
- Publishes these results once per frame for the overlay/tracking logic downstream.

Parameters:
- XW, 12, width of column counter and box x outputs
- YW, 12, width of row counter and box y outputs
- CW, 22, width of hit-pixel counter
- MIN_PIX, 16, minimum hits per frame for box_valid=1

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- hsv_h  in  9  hue 0..360
- hsv_s  in  9  saturation 0..256
- hsv_v  in  8  value 0..255
- hsv_vs  in  1  vsync, active-high; rising edge = frame boundary
- hsv_hs  in  1  hsync (only delayed)
- hsv_de  in  1  data enable
- h_lo, h_hi  in  9 each  hue window; h_lo>h_hi means wrap through 0
- s_lo, s_hi  in  9 each  saturation window, inclusive
- v_lo, v_hi  in  8 each  value window, inclusive
- mask  out  1  1 = pixel inside window
- mask_vs, mask_hs, mask_de  out  1 each  syncs delayed to align with mask
- box_x_min, box_x_max  out  XW  published box columns
- box_y_min, box_y_max  out  YW  published box rows
- box_cnt  out  CW  published hit count
- box_valid  out  1  box_cnt >= MIN_PIX for published frame
- box_update  out  1  one-cycle pulse when the box_* outputs change

Behaviour:
- Reset: every output 0. Thresholds are shadowed; shadows reset to 0.
- Accumulators after reset: x_min and y_min all-ones; x_max, y_max and cnt 0. x/y counters 0. FSM in WAIT.
- Frame edge fe = hsv_vs & ~vs_d, where vs_d is hsv_vs registered.
- Threshold shadows load all six window inputs on fe. Mid-frame input changes have no effect until the next fe.
- Hue match:
  - if h_lo<=h_hi: h_lo<=h<=h_hi
  - else: h>=h_lo or h<=h_hi
- Saturation and value match: lo<=x<=hi. If lo>hi, nothing matches.
- hit = hsv_de & h_match & s_match & v_match. Comparisons use shadow values.
- Mask latency is exactly 1 clk: mask, mask_vs, mask_hs, mask_de are registered copies of hit, hsv_vs, hsv_hs, hsv_de. de=0 forces mask=0.
- Column counter x:
  - increments on each de=1 cycle
  - clears to 0 on the cycle after de falls
  - saturates at all-ones
  - the current pixel's coordinate is the pre-increment value
- Row counter y:
  - increments on de falling edge (de_d & ~hsv_de)
  - clears on fe
  - saturates at all-ones
- On hit: x_min=min(x_min,x), x_max=max(x_max,x), y_min=min, y_max=max. cnt increments, saturating at all-ones.
- FSM states:
  - WAIT: after reset. Ignore pixels. On fe, clear accumulators and go to RUN. No box_update.
  - RUN: accumulate. On fe, publish: copy accumulators to box_*, set box_valid=(cnt>=MIN_PIX), pulse box_update the cycle after fe. Clear accumulators and counters the same cycle. Stay in RUN.
- Publishing with cnt=0 gives box_x_min/y_min = all-ones, max = 0, box_valid=0.
- Simultaneous fe and de=1 with a hit: the pixel counts into the new frame at (0,0), after clear.
- box_* hold their values between updates.
- reset_n asserted mid-frame: immediate return to reset state. The partial frame is never published.

Decomposition:
- Shared package hsv_pkg holds:
  - HSV widths: H_W=9, S_W=9, V_W=8
  - range constants H_MAX=360, S_MAX=256
  - FSM state enum {WAIT, RUN}
- One sub-module, hsv_window_cmp: the combinational hue-wrap/s/v window compare, reused by other colour-key blocks.

Test Plan:
- Window h 100..140, s 128..256, v 64..255. Pixel (120,200,100) with de=1 -> mask=1 one clk later. Pixel (141,200,100) -> mask=0. mask_de/vs/hs equal the inputs delayed by 1.
- Hue wrap window h_lo=340, h_hi=20. Hues 350, 0, 20 -> mask=1. Hues 21, 339 -> mask=0.
- 64x48 frame, hits at (10,5), (30,5), (20,40), cnt=3, MIN_PIX=2.
  - After the next vs rise: box_update pulse; box = x 10..30, y 5..40, box_cnt=3, box_valid=1.
  - Outputs stay unchanged until the following frame edge.
- First vs after reset -> no box_update. Frame with zero hits -> box_update, box_cnt=0, box_valid=0, x_min=4095, x_max=0.
- Change h_lo/h_hi mid-frame -> masks of the remaining pixels follow the old window. New window takes effect from the next frame.
- Assert reset_n low mid-frame for 1 cycle -> all outputs 0, FSM WAIT. The next vs rise gives no box_update. The frame after that publishes correctly.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared HSV stream widths, ranges and tracker FSM state encoding.
package hsv_pkg;

  localparam int unsigned H_W = 9;
  localparam int unsigned S_W = 9;
  localparam int unsigned V_W = 8;

  localparam int unsigned H_MAX = 360;
  localparam int unsigned S_MAX = 256;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } track_state_e;

endpackage

// File: rtl/hsv_window_cmp.sv
// Combinational HSV window compare; hue window wraps through 0 when h_lo > h_hi.
module hsv_window_cmp
  import hsv_pkg::*;
(
  input  logic [H_W-1:0] h,
  input  logic [S_W-1:0] s,
  input  logic [V_W-1:0] v,
  input  logic [H_W-1:0] h_lo,
  input  logic [H_W-1:0] h_hi,
  input  logic [S_W-1:0] s_lo,
  input  logic [S_W-1:0] s_hi,
  input  logic [V_W-1:0] v_lo,
  input  logic [V_W-1:0] v_hi,
  output logic           match_c
);

  logic h_match_c;
  logic s_match_c;
  logic v_match_c;

  always_comb begin
    if (h_lo <= h_hi) h_match_c = (h >= h_lo) && (h <= h_hi);
    else              h_match_c = (h >= h_lo) || (h <= h_hi);
    s_match_c = (s >= s_lo) && (s <= s_hi);
    v_match_c = (v >= v_lo) && (v <= v_hi);
    match_c   = h_match_c & s_match_c & v_match_c;
  end

endmodule

// File: rtl/hsv_color_track.sv
// HSV colour keying to a 1-bit mask stream plus per-frame bounding box / hit count.
module hsv_color_track
  import hsv_pkg::*;
#(
  parameter int unsigned XW      = 12,
  parameter int unsigned YW      = 12,
  parameter int unsigned CW      = 22,
  parameter int unsigned MIN_PIX = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [H_W-1:0] hsv_h,
  input  logic [S_W-1:0] hsv_s,
  input  logic [V_W-1:0] hsv_v,
  input  logic           hsv_vs,
  input  logic           hsv_hs,
  input  logic           hsv_de,
  input  logic [H_W-1:0] h_lo,
  input  logic [H_W-1:0] h_hi,
  input  logic [S_W-1:0] s_lo,
  input  logic [S_W-1:0] s_hi,
  input  logic [V_W-1:0] v_lo,
  input  logic [V_W-1:0] v_hi,
  output logic           mask,
  output logic           mask_vs,
  output logic           mask_hs,
  output logic           mask_de,
  output logic [XW-1:0]  box_x_min,
  output logic [XW-1:0]  box_x_max,
  output logic [YW-1:0]  box_y_min,
  output logic [YW-1:0]  box_y_max,
  output logic [CW-1:0]  box_cnt,
  output logic           box_valid,
  output logic           box_update
);

  track_state_e state_q, state_d;

  logic vs_q, vs_d, de_q, de_d;
  logic [H_W-1:0] sh_h_lo_q, sh_h_lo_d, sh_h_hi_q, sh_h_hi_d;
  logic [S_W-1:0] sh_s_lo_q, sh_s_lo_d, sh_s_hi_q, sh_s_hi_d;
  logic [V_W-1:0] sh_v_lo_q, sh_v_lo_d, sh_v_hi_q, sh_v_hi_d;
  logic mask_q, mask_d, mask_vs_q, mask_vs_d, mask_hs_q, mask_hs_d, mask_de_q, mask_de_d;
  logic [XW-1:0] x_q, x_d, acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [YW-1:0] y_q, y_d, acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [XW-1:0] box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
  logic [YW-1:0] box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
  logic [CW-1:0] box_cnt_q, box_cnt_d;
  logic box_valid_q, box_valid_d, box_update_q, box_update_d;

  logic          fe_c, de_fall_c, win_match_c, hit_c;
  logic [XW-1:0] px_x_c;
  logic [YW-1:0] px_y_c;

  hsv_window_cmp u_cmp (
    .h       (hsv_h),
    .s       (hsv_s),
    .v       (hsv_v),
    .h_lo    (sh_h_lo_q),
    .h_hi    (sh_h_hi_q),
    .s_lo    (sh_s_lo_q),
    .s_hi    (sh_s_hi_q),
    .v_lo    (sh_v_lo_q),
    .v_hi    (sh_v_hi_q),
    .match_c (win_match_c)
  );

  assign fe_c      = hsv_vs & ~vs_q;
  assign de_fall_c = de_q & ~hsv_de;
  assign hit_c     = hsv_de & win_match_c;
  // A pixel coincident with the frame edge lands at (0,0) of the new frame.
  assign px_x_c    = fe_c ? '0 : x_q;
  assign px_y_c    = fe_c ? '0 : y_q;

  always_comb begin
    state_d      = state_q;
    vs_d         = hsv_vs;
    de_d         = hsv_de;
    sh_h_lo_d    = sh_h_lo_q;
    sh_h_hi_d    = sh_h_hi_q;
    sh_s_lo_d    = sh_s_lo_q;
    sh_s_hi_d    = sh_s_hi_q;
    sh_v_lo_d    = sh_v_lo_q;
    sh_v_hi_d    = sh_v_hi_q;
    mask_d       = hit_c;
    mask_vs_d    = hsv_vs;
    mask_hs_d    = hsv_hs;
    mask_de_d    = hsv_de;
    x_d          = x_q;
    y_d          = y_q;
    acc_x_min_d  = acc_x_min_q;
    acc_x_max_d  = acc_x_max_q;
    acc_y_min_d  = acc_y_min_q;
    acc_y_max_d  = acc_y_max_q;
    acc_cnt_d    = acc_cnt_q;
    box_x_min_d  = box_x_min_q;
    box_x_max_d  = box_x_max_q;
    box_y_min_d  = box_y_min_q;
    box_y_max_d  = box_y_max_q;
    box_cnt_d    = box_cnt_q;
    box_valid_d  = box_valid_q;
    box_update_d = 1'b0;

    if (fe_c) begin
      sh_h_lo_d = h_lo;
      sh_h_hi_d = h_hi;
      sh_s_lo_d = s_lo;
      sh_s_hi_d = s_hi;
      sh_v_lo_d = v_lo;
      sh_v_hi_d = v_hi;
    end

    if (!hsv_de)            x_d = '0;
    else if (px_x_c != '1)  x_d = px_x_c + XW'(1);
    else                    x_d = px_x_c;

    if (fe_c)                          y_d = '0;
    else if (de_fall_c && y_q != '1)   y_d = y_q + YW'(1);

    // Publish the finished frame before its accumulators are cleared.
    if (fe_c && state_q == RUN) begin
      box_x_min_d  = acc_x_min_q;
      box_x_max_d  = acc_x_max_q;
      box_y_min_d  = acc_y_min_q;
      box_y_max_d  = acc_y_max_q;
      box_cnt_d    = acc_cnt_q;
      box_valid_d  = (acc_cnt_q >= CW'(MIN_PIX));
      box_update_d = 1'b1;
    end

    if (fe_c) begin
      state_d     = RUN;
      acc_x_min_d = '1;
      acc_x_max_d = '0;
      acc_y_min_d = '1;
      acc_y_max_d = '0;
      acc_cnt_d   = '0;
    end

    if ((state_q == RUN || fe_c) && hit_c) begin
      if (px_x_c < acc_x_min_d) acc_x_min_d = px_x_c;
      if (px_x_c > acc_x_max_d) acc_x_max_d = px_x_c;
      if (px_y_c < acc_y_min_d) acc_y_min_d = px_y_c;
      if (px_y_c > acc_y_max_d) acc_y_max_d = px_y_c;
      if (acc_cnt_d != '1)      acc_cnt_d   = acc_cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      sh_h_lo_q    <= '0;
      sh_h_hi_q    <= '0;
      sh_s_lo_q    <= '0;
      sh_s_hi_q    <= '0;
      sh_v_lo_q    <= '0;
      sh_v_hi_q    <= '0;
      mask_q       <= 1'b0;
      mask_vs_q    <= 1'b0;
      mask_hs_q    <= 1'b0;
      mask_de_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      acc_x_min_q  <= '1;
      acc_x_max_q  <= '0;
      acc_y_min_q  <= '1;
      acc_y_max_q  <= '0;
      acc_cnt_q    <= '0;
      box_x_min_q  <= '0;
      box_x_max_q  <= '0;
      box_y_min_q  <= '0;
      box_y_max_q  <= '0;
      box_cnt_q    <= '0;
      box_valid_q  <= 1'b0;
      box_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      sh_h_lo_q    <= sh_h_lo_d;
      sh_h_hi_q    <= sh_h_hi_d;
      sh_s_lo_q    <= sh_s_lo_d;
      sh_s_hi_q    <= sh_s_hi_d;
      sh_v_lo_q    <= sh_v_lo_d;
      sh_v_hi_q    <= sh_v_hi_d;
      mask_q       <= mask_d;
      mask_vs_q    <= mask_vs_d;
      mask_hs_q    <= mask_hs_d;
      mask_de_q    <= mask_de_d;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_x_min_q  <= acc_x_min_d;
      acc_x_max_q  <= acc_x_max_d;
      acc_y_min_q  <= acc_y_min_d;
      acc_y_max_q  <= acc_y_max_d;
      acc_cnt_q    <= acc_cnt_d;
      box_x_min_q  <= box_x_min_d;
      box_x_max_q  <= box_x_max_d;
      box_y_min_q  <= box_y_min_d;
      box_y_max_q  <= box_y_max_d;
      box_cnt_q    <= box_cnt_d;
      box_valid_q  <= box_valid_d;
      box_update_q <= box_update_d;
    end
  end

  assign mask       = mask_q;
  assign mask_vs    = mask_vs_q;
  assign mask_hs    = mask_hs_q;
  assign mask_de    = mask_de_q;
  assign box_x_min  = box_x_min_q;
  assign box_x_max  = box_x_max_q;
  assign box_y_min  = box_y_min_q;
  assign box_y_max  = box_y_max_q;
  assign box_cnt    = box_cnt_q;
  assign box_valid  = box_valid_q;
  assign box_update = box_update_q;

endmodule

// File: tb/tb_hsv_color_track.sv
// Directed bench for hsv_color_track: mask vectors, hue wrap, shadowing, box publish, reset.
module tb_hsv_color_track;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  hsv_h, hsv_s, h_lo, h_hi, s_lo, s_hi;
  logic [7:0]  hsv_v, v_lo, v_hi;
  logic        hsv_vs, hsv_hs, hsv_de;
  logic        mask, mask_vs, mask_hs, mask_de;
  logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [21:0] box_cnt;
  logic        box_valid, box_update;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] h;
    logic [8:0] s;
    logic [7:0] v;
    logic       de;
    logic       hs;
    logic       exp_mask;
  } vec_t;

  vec_t tab [14];

  always #5 clk = ~clk;

  hsv_color_track #(.XW(12), .YW(12), .CW(22), .MIN_PIX(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .hsv_h(hsv_h), .hsv_s(hsv_s), .hsv_v(hsv_v),
    .hsv_vs(hsv_vs), .hsv_hs(hsv_hs), .hsv_de(hsv_de),
    .h_lo(h_lo), .h_hi(h_hi), .s_lo(s_lo), .s_hi(s_hi), .v_lo(v_lo), .v_hi(v_hi),
    .mask(mask), .mask_vs(mask_vs), .mask_hs(mask_hs), .mask_de(mask_de),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max),
    .box_cnt(box_cnt), .box_valid(box_valid), .box_update(box_update)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_win(input int hl, input int hh, input int sl, input int sh,
                         input int vl, input int vh);
    h_lo = 9'(hl); h_hi = 9'(hh); s_lo = 9'(sl); s_hi = 9'(sh);
    v_lo = 8'(vl); v_hi = 8'(vh);
  endtask

  // Drive one cycle of pixel data; called just after a falling edge.
  task automatic px(input int h, input logic de);
    hsv_h = 9'(h); hsv_s = 9'd200; hsv_v = 8'd100; hsv_de = de; hsv_hs = 1'b0;
    @(negedge clk);
  endtask

  // Raise vsync for two cycles; report whether box_update pulsed exactly once.
  task automatic frame_edge(output logic pulsed);
    logic u1, u2;
    hsv_vs = 1'b1; hsv_de = 1'b0;
    @(negedge clk);
    u1 = box_update;
    chk("mask_vs_delay", 32'(mask_vs), 32'd1);
    @(negedge clk);
    u2 = box_update;
    hsv_vs = 1'b0;
    @(negedge clk);
    pulsed = u1 & ~u2;
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      hsv_h = tab[i].h; hsv_s = tab[i].s; hsv_v = tab[i].v;
      hsv_de = tab[i].de; hsv_hs = tab[i].hs;
      @(negedge clk);
      chk($sformatf("mask_vec%0d", i), 32'(mask), 32'(tab[i].exp_mask));
      chk($sformatf("mask_de_vec%0d", i), 32'(mask_de), 32'(tab[i].de));
      chk($sformatf("mask_hs_vec%0d", i), 32'(mask_hs), 32'(tab[i].hs));
    end
    hsv_de = 1'b0; hsv_hs = 1'b0;
    @(negedge clk);
  endtask

  // Raster w x hgt with 4 blank cycles per row; hue 120 at listed hits, 0 elsewhere.
  task automatic run_frame(input int w, input int hgt, input int nh,
                           input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
    for (int y = 0; y < hgt; y++) begin
      for (int x = 0; x < w; x++) begin
        if ((nh > 0 && x == x0 && y == y0) || (nh > 1 && x == x1 && y == y1) ||
            (nh > 2 && x == x2 && y == y2))
          px(120, 1'b1);
        else
          px(0, 1'b1);
      end
      for (int b = 0; b < 4; b++) px(0, 1'b0);
    end
  endtask

  task automatic chk_box(input string tag, input int xmn, input int xmx, input int ymn,
                         input int ymx, input int cnt, input int vld);
    chk({tag, "_x_min"}, 32'(box_x_min), 32'(xmn));
    chk({tag, "_x_max"}, 32'(box_x_max), 32'(xmx));
    chk({tag, "_y_min"}, 32'(box_y_min), 32'(ymn));
    chk({tag, "_y_max"}, 32'(box_y_max), 32'(ymx));
    chk({tag, "_cnt"},   32'(box_cnt),   32'(cnt));
    chk({tag, "_valid"}, 32'(box_valid), 32'(vld));
  endtask

  initial begin
    logic pulsed;
    logic saw_upd;

    // Window A: h 100..140, s 128..256, v 64..255
    tab[0]  = '{9'd120, 9'd200, 8'd100, 1'b1, 1'b0, 1'b1};
    tab[1]  = '{9'd141, 9'd200, 8'd100, 1'b1, 1'b1, 1'b0};
    tab[2]  = '{9'd120, 9'd200, 8'd100, 1'b0, 1'b1, 1'b0};
    tab[3]  = '{9'd100, 9'd128, 8'd64,  1'b1, 1'b0, 1'b1};
    tab[4]  = '{9'd140, 9'd256, 8'd255, 1'b1, 1'b0, 1'b1};
    tab[5]  = '{9'd99,  9'd200, 8'd100, 1'b1, 1'b0, 1'b0};
    tab[6]  = '{9'd120, 9'd127, 8'd100, 1'b1, 1'b1, 1'b0};
    tab[7]  = '{9'd120, 9'd200, 8'd63,  1'b1, 1'b0, 1'b0};
    // Wrap window: h 340..20, s 0..256, v 0..255
    tab[8]  = '{9'd350, 9'd200, 8'd100, 1'b1, 1'b0, 1'b1};
    tab[9]  = '{9'd0,   9'd200, 8'd100, 1'b1, 1'b1, 1'b1};
    tab[10] = '{9'd20,  9'd200, 8'd100, 1'b1, 1'b0, 1'b1};
    tab[11] = '{9'd21,  9'd200, 8'd100, 1'b1, 1'b0, 1'b0};
    tab[12] = '{9'd339, 9'd200, 8'd100, 1'b1, 1'b1, 1'b0};
    tab[13] = '{9'd360, 9'd200, 8'd100, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b0;
    hsv_h = '0; hsv_s = '0; hsv_v = '0; hsv_vs = 1'b0; hsv_hs = 1'b0; hsv_de = 1'b0;
    set_win(100, 140, 128, 256, 64, 255);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_mask_vs", 32'(mask_vs), 32'd0);
    chk("rst_update", 32'(box_update), 32'd0);
    chk_box("rst", 0, 0, 0, 0, 0, 0);

    // First frame edge after reset leaves WAIT without publishing
    frame_edge(pulsed);
    chk("first_fe_no_update", 32'(pulsed), 32'd0);
    run_vecs(0, 7);

    set_win(340, 20, 0, 256, 0, 255);
    frame_edge(pulsed);
    chk("fe_publish_pulse", 32'(pulsed), 32'd1);
    run_vecs(8, 13);

    // Mid-frame window change must not take effect until the next frame
    set_win(100, 140, 0, 256, 0, 255);
    px(0, 1'b1);
    chk("shadow_old_h0", 32'(mask), 32'd1);
    px(120, 1'b1);
    chk("shadow_old_h120", 32'(mask), 32'd0);
    px(0, 1'b0);
    frame_edge(pulsed);
    px(120, 1'b1);
    chk("shadow_new_h120", 32'(mask), 32'd1);
    px(0, 1'b1);
    chk("shadow_new_h0", 32'(mask), 32'd0);
    px(0, 1'b0);

    // Clean 64x48 frame with three hits
    frame_edge(pulsed);
    run_frame(64, 48, 3, 10, 5, 30, 5, 20, 40);
    frame_edge(pulsed);
    chk("box_frame_pulse", 32'(pulsed), 32'd1);
    chk_box("box", 10, 30, 5, 40, 3, 1);

    saw_upd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      px(0, (i % 5) != 4);
      if (box_update) saw_upd = 1'b1;
    end
    chk("hold_no_update", 32'(saw_upd), 32'd0);
    chk_box("hold", 10, 30, 5, 40, 3, 1);

    // Zero-hit frame
    frame_edge(pulsed);
    run_frame(8, 4, 0, 0, 0, 0, 0, 0, 0);
    frame_edge(pulsed);
    chk("zero_pulse", 32'(pulsed), 32'd1);
    chk_box("zero", 4095, 0, 4095, 0, 0, 0);

    // Mid-frame reset discards the partial frame
    run_frame(8, 2, 1, 3, 1, 0, 0, 0, 0);
    px(120, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mask", 32'(mask), 32'd0);
    chk("mid_rst_mask_de", 32'(mask_de), 32'd0);
    chk_box("mid_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    px(120, 1'b1);
    px(0, 1'b0);
    frame_edge(pulsed);
    chk("post_rst_no_update", 32'(pulsed), 32'd0);
    chk_box("post_rst_hold", 0, 0, 0, 0, 0, 0);
    run_frame(16, 8, 2, 3, 2, 7, 6, 0, 0);
    frame_edge(pulsed);
    chk("post_rst_pulse", 32'(pulsed), 32'd1);
    chk_box("post_rst", 3, 7, 2, 6, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
